// File: rtl/rm_update_issuer.sv
// RM-ID update initiator: queues region/module updates and issues framed strobes.
// Optional readback shadow of issued values under `RM_UPDATE_SHADOW_EN.
module rm_update_issuer #(
  parameter int NUM_REGIONS = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_rrid,
  input  logic [3:0] req_val,
  output logic       update,
  output logic [3:0] rrid,
  output logic [3:0] update_val,
  output logic       busy,
  output logic       err_rrid,
  input  logic       err_clr
`ifdef RM_UPDATE_SHADOW_EN
  ,
  input  logic [3:0] shd_rrid,
  output logic [3:0] shd_val
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]    NREG   = 5'(NUM_REGIONS);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [GW-1:0] gap;
  logic          in_range;
  logic          accept;
  logic          push;
  logic          pop;

  assign req_ready = (count != FULL);
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, req_rrid} < NREG);
  assign push      = accept && in_range;
  assign pop       = (state == IDLE) && (count != '0);
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_rrid, req_val};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // rrid/update_val load only on the pop so they frame the whole pulse+gap
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      update     <= 1'b0;
      rrid       <= '0;
      update_val <= '0;
      gap        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            {rrid, update_val} <= mem[rptr];
            update <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          update <= 1'b0;
          gap    <= GAP_LD;
          state  <= SETTLE;
        end
        SETTLE: begin
          if (gap == '0) state <= IDLE;
          else           gap   <= gap - 1'b1;
        end
        default: begin
          update <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // a new error outranks a coincident clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 err_rrid <= 1'b0;
    else if (accept && !in_range) err_rrid <= 1'b1;
    else if (err_clr)            err_rrid <= 1'b0;
  end

`ifdef RM_UPDATE_SHADOW_EN
  logic [3:0] shadow [NUM_REGIONS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGIONS; i++) shadow[i] <= '0;
    end else if (state == DRIVE) begin
      for (int i = 0; i < NUM_REGIONS; i++)
        if (rrid == 4'(i)) shadow[i] <= update_val;
    end
  end

  always_comb begin
    shd_val = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (shd_rrid == 4'(i)) shd_val = shadow[i];
  end
`endif

endmodule
